// File: rtl/jtag_idcode_reader.sv
// Host-side JTAG initiator: forces the target TAP through Test-Logic-Reset,
// shifts out the 32-bit IDCODE and returns the TAP to Run-Test/Idle.
module jtag_idcode_reader #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        TRST,
  input  logic        start,
  input  logic        tdo,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  output logic        busy,
  output logic        done,
  output logic [31:0] idcode,
  output logic        id_valid
);

  // state   | meaning
  // IDLE    | waiting for start, tck parked low
  // RESET   | 5 TCK periods tms=1 -> Test-Logic-Reset
  // NAV     | 4 TCK periods tms=0,1,0,0 -> Shift-DR
  // SHIFT   | 32 TCK periods, tdo sampled on rising tck, tms=1 on the last
  // EXIT    | 2 TCK periods tms=1,0 -> Update-DR, Run-Test/Idle
  // DONE    | one clk: publish idcode/id_valid, pulse done
  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_NAV, S_SHIFT, S_EXIT, S_DONE
  } state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t        state, state_nxt, adv_state;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [5:0]    bit_cnt, bit_nxt, last_cnt;
  logic [31:0]   sr, sr_nxt, idcode_nxt;
  logic          tck_nxt, tms_nxt, tdi_nxt, busy_nxt, done_nxt, valid_nxt;
  logic          phase_end, tck_rise, tck_fall;

  // TMS value driven during period n of a state
  function automatic logic tms_for(input state_t s, input logic [5:0] n);
    case (s)
      S_NAV:   return (n == 6'd1);
      S_SHIFT: return (n == 6'd31);
      S_EXIT:  return (n == 6'd0);
      default: return 1'b1;
    endcase
  endfunction

  assign phase_end = (div_cnt == DW'(CLK_DIV - 1));
  assign tck_rise  = phase_end && !tck;
  assign tck_fall  = phase_end && tck;

  always_comb begin
    adv_state = S_DONE;
    last_cnt  = 6'd0;
    case (state)
      S_RESET: begin adv_state = S_NAV;   last_cnt = 6'd4;  end
      S_NAV:   begin adv_state = S_SHIFT; last_cnt = 6'd3;  end
      S_SHIFT: begin adv_state = S_EXIT;  last_cnt = 6'd31; end
      S_EXIT:  begin adv_state = S_DONE;  last_cnt = 6'd1;  end
      default: begin adv_state = S_DONE;  last_cnt = 6'd0;  end
    endcase
  end

  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    sr_nxt     = sr;
    idcode_nxt = idcode;
    tck_nxt    = tck;
    tms_nxt    = tms;
    tdi_nxt    = tdi;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    valid_nxt  = id_valid;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_RESET;
          busy_nxt   = 1'b1;
          idcode_nxt = '0;
          sr_nxt     = '0;
          tms_nxt    = 1'b1;
          tdi_nxt    = 1'b1;
          tck_nxt    = 1'b0;
          div_nxt    = '0;
          bit_nxt    = '0;
        end
      end
      S_RESET, S_NAV, S_SHIFT, S_EXIT: begin
        div_nxt = phase_end ? '0 : div_cnt + DW'(1);
        if (phase_end)
          tck_nxt = ~tck;
        if (tck_rise && state == S_SHIFT)
          sr_nxt = {tdo, sr[31:1]};
        // period boundary: advance counter/state and present the next tms
        if (tck_fall) begin
          if (bit_cnt == last_cnt) begin
            state_nxt = adv_state;
            bit_nxt   = '0;
            tms_nxt   = tms_for(adv_state, 6'd0);
          end else begin
            bit_nxt = bit_cnt + 6'd1;
            tms_nxt = tms_for(state, bit_cnt + 6'd1);
          end
        end
      end
      S_DONE: begin
        state_nxt  = S_IDLE;
        idcode_nxt = sr;
        valid_nxt  = sr[0] && (sr != 32'hFFFF_FFFF);
        done_nxt   = 1'b1;
        busy_nxt   = 1'b0;
        tms_nxt    = 1'b1;
        tck_nxt    = 1'b0;
        div_nxt    = '0;
        bit_nxt    = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      idcode   <= '0;
      tck      <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      sr       <= sr_nxt;
      idcode   <= idcode_nxt;
      tck      <= tck_nxt;
      tms      <= tms_nxt;
      tdi      <= tdi_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      id_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Bench for jtag_idcode_reader: two instances (CLK_DIV=2 and 1), each driving
// a behavioural target TAP; expected reads are queued and checked on done.
module tb_jtag_idcode_reader;

  localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SELDR = 4'd2, CAPDR = 4'd3,
                         SHDR = 4'd4, EX1DR = 4'd5, PAUDR = 4'd6, EX2DR = 4'd7,
                         UPDDR = 4'd8, SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11,
                         EX1IR = 4'd12, PAUIR = 4'd13, EX2IR = 4'd14, UPDIR = 4'd15;

  typedef struct {
    logic [31:0] code;
    logic        valid;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic trst, start0, start1;
  logic tdo0, tck0, tms0, tdi0, busy0, done0, valid0;
  logic tdo1, tck1, tms1, tdi1, busy1, done1, valid1;
  logic [31:0] id0, id1;

  int tests = 0, failed = 0;
  int cyc = 0;
  exp_t q0[$], q1[$];

  jtag_idcode_reader #(.CLK_DIV(2)) u_dut0 (
    .clk(clk), .TRST(trst), .start(start0), .tdo(tdo0), .tck(tck0), .tms(tms0),
    .tdi(tdi0), .busy(busy0), .done(done0), .idcode(id0), .id_valid(valid0));

  jtag_idcode_reader #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .TRST(trst), .start(start1), .tdo(tdo1), .tck(tck1), .tms(tms1),
    .tdi(tdi1), .busy(busy1), .done(done1), .idcode(id1), .id_valid(valid1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDDR : PAUDR;
      PAUDR:   return m ? EX2DR : PAUDR;
      EX2DR:   return m ? UPDDR : SHDR;
      UPDDR:   return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPDIR : PAUIR;
      PAUIR:   return m ? EX2IR : PAUIR;
      EX2IR:   return m ? UPDIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  // behavioural targets: mode 0 = real TAP, 1 = tdo stuck high, 2 = stuck low
  int mode0 = 0, mode1 = 0;
  logic [31:0] code0 = 32'h1000_1003, code1 = 32'h0BAD_F00D;
  logic [3:0]  tap0 = 4'($urandom_range(1, 15));
  logic [3:0]  tap1 = 4'($urandom_range(1, 15));
  logic [31:0] dr0 = '0, dr1 = '0;
  logic        ttdo0 = 1'b1, ttdo1 = 1'b1;

  always @(posedge tck0) begin
    if (tap0 == CAPDR)     dr0 <= code0;
    else if (tap0 == SHDR) dr0 <= {tdi0, dr0[31:1]};
    tap0 <= tap_next(tap0, tms0);
  end
  always @(negedge tck0) if (tap0 == SHDR) ttdo0 <= dr0[0];

  always @(posedge tck1) begin
    if (tap1 == CAPDR)     dr1 <= code1;
    else if (tap1 == SHDR) dr1 <= {tdi1, dr1[31:1]};
    tap1 <= tap_next(tap1, tms1);
  end
  always @(negedge tck1) if (tap1 == SHDR) ttdo1 <= dr1[0];

  assign tdo0 = (mode0 == 1) ? 1'b1 : (mode0 == 2) ? 1'b0 : ttdo0;
  assign tdo1 = (mode1 == 1) ? 1'b1 : (mode1 == 2) ? 1'b0 : ttdo1;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor / scoreboard
  logic        pb0 = 0, pb1 = 0, ptck0 = 0, ptck1 = 0, ptms0 = 1, ptms1 = 1, ptdi0 = 1, ptdi1 = 1;
  int          st0 = 0, st1 = 0, rises0 = 0, dn0 = 0, edge_viol = 0, per_viol = 0;
  logic [42:0] tms_log0 = '0;

  always @(negedge clk) begin
    if (busy0 && !pb0) begin st0 <= cyc; rises0 <= 0; tms_log0 <= '0; end
    else if (busy0 && !ptck0 && tck0) begin
      rises0   <= rises0 + 1;
      tms_log0 <= {tms_log0[41:0], tms0};
    end
    if (busy1 && !pb1) st1 <= cyc;
    if (pb0 && busy0 && (tms0 != ptms0 || tdi0 != ptdi0) && !(ptck0 && !tck0)) edge_viol <= edge_viol + 1;
    if (pb1 && busy1 && (tms1 != ptms1 || tdi1 != ptdi1) && !(ptck1 && !tck1)) edge_viol <= edge_viol + 1;
    if (pb1 && busy1 && tck1 == ptck1) per_viol <= per_viol + 1;
    if (done0) begin
      dn0 <= dn0 + 1;
      if (q0.size() == 0) chk("dut0_unexpected_done", 64'd1, 64'd0);
      else begin
        automatic exp_t e = q0.pop_front();
        chk("dut0_idcode", 64'(id0), 64'(e.code));
        chk("dut0_id_valid", 64'(valid0), 64'(e.valid));
        chk("dut0_latency", 64'(cyc - st0), 64'(e.lat));
        chk("dut0_target_rti", 64'(tap0), 64'(RTI));
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 64'd1, 64'd0);
      else begin
        automatic exp_t e = q1.pop_front();
        chk("dut1_idcode", 64'(id1), 64'(e.code));
        chk("dut1_id_valid", 64'(valid1), 64'(e.valid));
        chk("dut1_latency", 64'(cyc - st1), 64'(e.lat));
        chk("dut1_target_rti", 64'(tap1), 64'(RTI));
      end
    end
    pb0 <= busy0; pb1 <= busy1; ptck0 <= tck0; ptck1 <= tck1;
    ptms0 <= tms0; ptms1 <= tms1; ptdi0 <= tdi0; ptdi1 <= tdi1;
  end

  task automatic pulse0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    int n = 0;
    @(negedge clk);
    while (!done0 && n < budget) begin @(negedge clk); n++; end
    if (!done0) chk("dut0_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic push0(input logic [31:0] c, input logic v);
    exp_t e;
    e.code = c; e.valid = v; e.lat = 173;
    q0.push_back(e);
  endtask

  logic [42:0] tms_exp;
  int          dn_snap;

  initial begin
    tms_exp = {5'b11111, 4'b0100, 31'd0, 1'b1, 2'b10};
    trst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    #23;
    chk("reset_ctl", 64'({tck0, tms0, tdi0, busy0, done0, valid0}), 64'b011000);
    chk("reset_idcode", 64'(id0), 64'd0);
    @(negedge clk) trst = 1'b1;

    // nominal read, TMS sequence
    push0(32'h1000_1003, 1'b1);
    pulse0();
    wait_done0(400);
    chk("tms_sequence", 64'(tms_log0), 64'(tms_exp));
    repeat (5) @(negedge clk);
    chk("idcode_held", 64'(id0), 64'h1000_1003);
    chk("busy_cleared", 64'(busy0), 64'd0);

    // stuck TDO
    mode0 = 1; push0(32'hFFFF_FFFF, 1'b0); pulse0(); wait_done0(400);
    mode0 = 2; push0(32'h0000_0000, 1'b0); pulse0(); wait_done0(400);
    mode0 = 0;

    // CLK_DIV=1 instance
    begin
      exp_t e;
      int n = 0;
      e.code = 32'h0BAD_F00D; e.valid = 1'b1; e.lat = 87;
      q1.push_back(e);
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      @(negedge clk);
      while (!done1 && n < 200) begin @(negedge clk); n++; end
      if (!done1) chk("dut1_done_timeout", 64'd0, 64'd1);
      chk("dut1_tck_period", 64'(per_viol), 64'd0);
    end

    // start re-pulsed during SHIFT is ignored
    code0 = 32'h4BA0_0477;
    push0(32'h4BA0_0477, 1'b1);
    dn_snap = dn0;
    pulse0();
    repeat (80) @(negedge clk);
    pulse0();
    wait_done0(400);
    repeat (200) @(negedge clk);
    chk("single_done", 64'(dn0 - dn_snap), 64'd1);
    chk("idcode_unchanged", 64'(id0), 64'h4BA0_0477);

    // TRST during SHIFT bit 17
    code0 = 32'h1000_1003;
    pulse0();
    begin
      int n = 0;
      while (rises0 < 26 && n < 400) begin @(negedge clk); n++; end
      if (rises0 < 26) chk("abort_reach_timeout", 64'd0, 64'd1);
    end
    #2 trst = 1'b0;
    #1;
    chk("abort_ctl", 64'({tck0, tms0, tdi0, busy0, done0, valid0}), 64'b011000);
    chk("abort_idcode", 64'(id0), 64'd0);
    @(negedge clk) trst = 1'b1;

    code0 = 32'h2B01_A0DF;
    push0(32'h2B01_A0DF, 1'b1);
    pulse0();
    wait_done0(400);

    // start held high: back-to-back reads
    code0 = 32'h0BAD_F00D;
    push0(32'h0BAD_F00D, 1'b1);
    push0(32'h0BAD_F00D, 1'b1);
    @(negedge clk) start0 = 1'b1;
    wait_done0(400);
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done0(400);
    repeat (20) @(negedge clk);

    chk("edge_discipline", 64'(edge_viol), 64'd0);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/jtag_idcode_reader.md
Name: jtag_idcode_reader

Overview:
- Host-side JTAG initiator that reads a target's 32-bit device ID code.
- Generates TCK/TMS/TDI from the system clock and walks the target TAP: Test-Logic-Reset, then Run-Test/Idle, then Select-DR, Capture-DR, Shift-DR.
- Shifts out the 32-bit IDCODE LSB first, returns the TAP to Run-Test/Idle, and presents the captured code with a validity flag.
- Used by board-level self-test and by bring-up benches to exercise our target TAP and ID register.

Parameters:
CLK_DIV, 2, number of clk cycles per TCK half-period (min 1; TCK period = 2*CLK_DIV clk).

Ports:
clk  input  1  system clock; all logic is clocked on posedge clk.
TRST  input  1  reset, asynchronous, active-low.
start  input  1  request an IDCODE read; sampled only in IDLE.
tdo  input  1  target TDO.
tck  output  1  generated JTAG clock.
tms  output  1  JTAG mode select.
tdi  output  1  JTAG data to target.
busy  output  1  high while a read sequence is in progress.
done  output  1  one-clk pulse at the end of a sequence.
idcode  output  32  captured ID code; held until the next accepted start.
id_valid  output  1  captured code is a legal IDCODE; updated together with done.

Behaviour:
- Reset values (TRST low, asynchronous): tck=0, tms=1, tdi=1, busy=0, done=0, idcode=0, id_valid=0, FSM=IDLE, all counters 0.
- Reset mid-sequence aborts immediately to these values. No partial idcode is retained.
- TCK generation: while busy, tck is a register toggled every CLK_DIV clk cycles.
  - Each TCK period is a low phase then a high phase, starting low.
  - tms/tdi change only on the clk edge where tck goes 1->0, or at sequence start for the first bit.
  - tdo is sampled on the clk edge where tck goes 0->1, using the value present before that edge.
  - tck is held at 0 in IDLE/DONE.
- FSM states, with TMS value for each TCK period:
  - IDLE: wait for start. start=1 moves to RESET, sets busy=1 and clears idcode. start while busy is ignored.
  - RESET: 5 TCK periods with tms=1, forcing Test-Logic-Reset from any TAP state. IDCODE is the default instruction after reset.
  - NAV: 4 TCK periods with tms = 0,1,0,0 (RTI, Select-DR, Capture-DR, Shift-DR).
  - SHIFT: 32 TCK periods with tdi=1. tms=0 for periods 1..31 and tms=1 for period 32 (exit to Exit1-DR).
    - Each rising edge samples tdo into a shift register: sr <= {tdo, sr[31:1]}.
    - A 6-bit counter counts 0..31 and never wraps past 31.
  - EXIT: 2 TCK periods with tms = 1,0 (Update-DR, then Run-Test/Idle).
  - DONE: one clk cycle. Load idcode=sr, pulse done=1, set busy=0, tms=1. Return to IDLE.
- Total sequence is 43 TCK periods. done is high exactly 86*CLK_DIV+1 clk cycles after the start-accept edge.
- id_valid = (sr[0]==1) && (sr != 32'hFFFFFFFF). The all-ones value indicates BYPASS, no target, or a stuck-high TDO.
- start held high continuously: a new sequence begins on the clk after DONE returns to IDLE.

Test Plan:
- CLK_DIV=2, behavioural target with IDCODE 0x10001003, pulse start -> TMS sequence 11111 0100 (0x31) 1 10. done at cycle 173 after start; idcode=0x10001003, id_valid=1; target TAP ends in RTI.
- tdo tied 1 -> idcode=0xFFFFFFFF, id_valid=0. tdo tied 0 -> idcode=0x00000000, id_valid=0.
- Target code 0x0BADF00D, CLK_DIV=1 -> idcode=0x0BADF00D, id_valid=1, done at cycle 87. Check TCK period is 2 clk cycles, and that tms/tdi change only on tck falling edges.
- start pulsed again during SHIFT -> ignored; exactly one done pulse; idcode unchanged from the first read until the next accepted start.
- TRST asserted during SHIFT bit 17 -> all outputs immediately at reset values, idcode=0. Next start completes a full read with the correct code. Target starting in a random TAP state is still read correctly because RESET precedes NAV.
